// File: rtl/betting_ctrl.sv
// Heads-up no-limit hold'em hand sequencer feeding top_screen.
// Posts blinds, sequences turns, applies check/call, bet/raise and fold to the
// stacks, walks the streets preflop..showdown and awards the pot.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   start_hand                  pulse: begin a hand (IDLE or DONE without game_over)
//   action_valid/action/raise_amt  action of current_player (0 call, 1 raise, 2 fold, 3 ignored)
//   deal_req / deal_done        board-deal handshake for curr_state
//   eval_valid / eval_result    showdown result (0 p0, 1 p1, 2/3 split)
//   curr_state                  street: 0 preflop, 1 flop, 2 turn, 3 river, 4 showdown
//   current_player, current_dealer, player_stacks[2], player_pots[2], pot_size,
//   call_size, min_bet_or_raise, if_BetCheck, winner, hand_done, game_over
//   -- all registered, wired straight to top_screen.
module betting_ctrl #(
    parameter int unsigned STACK_W     = 11,
    parameter int unsigned START_STACK = 1000,
    parameter int unsigned SMALL_BLIND = 10,
    parameter int unsigned BIG_BLIND   = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_hand,
    input  logic               action_valid,
    input  logic [1:0]         action,
    input  logic [STACK_W-1:0] raise_amt,
    output logic               deal_req,
    input  logic               deal_done,
    input  logic               eval_valid,
    input  logic [1:0]         eval_result,
    output logic [2:0]         curr_state,
    output logic               current_player,
    output logic               current_dealer,
    output logic [STACK_W-1:0] player_stacks [2],
    output logic [STACK_W-1:0] player_pots [2],
    output logic [STACK_W-1:0] pot_size,
    output logic [STACK_W-1:0] call_size,
    output logic [STACK_W-1:0] min_bet_or_raise,
    output logic               if_BetCheck,
    output logic               winner,
    output logic               hand_done,
    output logic               game_over
);

    localparam logic [STACK_W-1:0] START_AMT = STACK_W'(START_STACK);
    localparam logic [STACK_W-1:0] SB_AMT    = STACK_W'(SMALL_BLIND);
    localparam logic [STACK_W-1:0] BB_AMT    = STACK_W'(BIG_BLIND);

    localparam logic [2:0] ST_PREFLOP  = 3'd0;
    localparam logic [2:0] ST_RIVER    = 3'd3;

    localparam logic [1:0] ACT_RAISE    = 2'd1;
    localparam logic [1:0] ACT_FOLD     = 2'd2;
    localparam logic [1:0] ACT_RESERVED = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_BLINDS, S_BET, S_SWEEP, S_DEAL, S_SHOWDOWN, S_AWARD, S_DONE
    } fsm_t;

    fsm_t       state;
    logic [1:0] acted;
    logic       skip_bet;
    logic       split;

    // Action arithmetic for the seat to act
    logic               opp;
    logic [STACK_W-1:0] stk_cur, stk_opp, pot_cur, pot_opp;
    logic [STACK_W-1:0] raise_inc, commit, refund;
    logic [STACK_W:0]   raise_total;
    logic               is_raise, full_raise, any_allin, street_closes;
    logic [STACK_W-1:0] new_stk_cur, new_stk_opp, new_pot_cur, new_pot_opp;

    always_comb begin
        opp         = ~current_player;
        stk_cur     = player_stacks[current_player];
        stk_opp     = player_stacks[opp];
        pot_cur     = player_pots[current_player];
        pot_opp     = player_pots[opp];
        raise_inc   = (raise_amt > min_bet_or_raise) ? raise_amt : min_bet_or_raise;
        raise_total = {1'b0, call_size} + {1'b0, raise_inc};
        // A stack that cannot exceed the call can only call
        is_raise    = (action == ACT_RAISE) && (stk_cur > call_size);
        if (is_raise) begin
            commit = (raise_total > {1'b0, stk_cur}) ? stk_cur : raise_total[STACK_W-1:0];
            refund = '0;
        end else begin
            commit = (stk_cur < call_size) ? stk_cur : call_size;
            // Uncalled part of the opponent's bet goes back so the pots level out
            refund = call_size - commit;
        end
        full_raise    = is_raise && ((commit - call_size) >= min_bet_or_raise);
        new_stk_cur   = stk_cur - commit;
        new_stk_opp   = stk_opp + refund;
        new_pot_cur   = pot_cur + commit;
        new_pot_opp   = pot_opp - refund;
        any_allin     = (new_stk_cur == '0) || (new_stk_opp == '0);
        // A raise reopens the action, so only a call/check can complete both flags
        street_closes = (new_pot_cur == new_pot_opp) &&
                        ((!is_raise && acted[opp]) || any_allin);
    end

    // Blind posting; the small blind never exceeds what the big blind could post
    logic               non_dealer;
    logic [STACK_W-1:0] stk_dlr, stk_bb, bb_post, sb_post;

    always_comb begin
        non_dealer = ~current_dealer;
        stk_dlr    = player_stacks[current_dealer];
        stk_bb     = player_stacks[non_dealer];
        bb_post    = (stk_bb < BB_AMT) ? stk_bb : BB_AMT;
        sb_post    = (stk_dlr < SB_AMT) ? stk_dlr : SB_AMT;
        if (sb_post > bb_post) sb_post = bb_post;
    end

    // Pot award; on a split the non-dealer takes the odd chip
    logic [STACK_W-1:0] award_total, award_half, share0, share1, award_stk0, award_stk1;

    always_comb begin
        award_total = pot_size + player_pots[0] + player_pots[1];
        award_half  = award_total >> 1;
        if (split) begin
            share0 = current_dealer ? (award_total - award_half) : award_half;
            share1 = current_dealer ? award_half : (award_total - award_half);
        end else begin
            share0 = winner ? '0 : award_total;
            share1 = winner ? award_total : '0;
        end
        award_stk0 = player_stacks[0] + share0;
        award_stk1 = player_stacks[1] + share1;
    end

    // Hand sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            acted            <= '0;
            skip_bet         <= 1'b0;
            split            <= 1'b0;
            deal_req         <= 1'b0;
            curr_state       <= ST_PREFLOP;
            current_player   <= 1'b0;
            current_dealer   <= 1'b1;
            player_stacks[0] <= START_AMT;
            player_stacks[1] <= START_AMT;
            player_pots[0]   <= '0;
            player_pots[1]   <= '0;
            pot_size         <= '0;
            call_size        <= '0;
            min_bet_or_raise <= BB_AMT;
            if_BetCheck      <= 1'b1;
            winner           <= 1'b0;
            hand_done        <= 1'b0;
            game_over        <= 1'b0;
        end else begin
            hand_done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_hand && !game_over) begin
                        current_dealer   <= ~current_dealer;
                        curr_state       <= ST_PREFLOP;
                        acted            <= '0;
                        skip_bet         <= 1'b0;
                        split            <= 1'b0;
                        min_bet_or_raise <= BB_AMT;
                        game_over        <= 1'b0;
                        state            <= S_BLINDS;
                    end
                end
                S_BLINDS: begin
                    player_stacks[current_dealer] <= stk_dlr - sb_post;
                    player_stacks[non_dealer]     <= stk_bb - bb_post;
                    player_pots[current_dealer]   <= sb_post;
                    player_pots[non_dealer]       <= bb_post;
                    current_player                <= current_dealer;
                    call_size                     <= bb_post - sb_post;
                    if_BetCheck                   <= (bb_post == sb_post);
                    state                         <= S_BET;
                end
                S_BET: begin
                    if (action_valid && action != ACT_RESERVED) begin
                        if (action == ACT_FOLD) begin
                            // Seat and call_size stay put; AWARD clears the pots
                            winner <= opp;
                            split  <= 1'b0;
                            state  <= S_AWARD;
                        end else begin
                            player_stacks[current_player] <= new_stk_cur;
                            player_stacks[opp]            <= new_stk_opp;
                            player_pots[current_player]   <= new_pot_cur;
                            player_pots[opp]              <= new_pot_opp;
                            current_player                <= opp;
                            call_size                     <= new_pot_cur - new_pot_opp;
                            if_BetCheck                   <= (new_pot_cur == new_pot_opp);
                            if (full_raise) min_bet_or_raise <= commit - call_size;
                            acted[current_player] <= 1'b1;
                            if (is_raise) acted[opp] <= 1'b0;
                            if (street_closes) begin
                                skip_bet <= skip_bet | any_allin;
                                state    <= S_SWEEP;
                            end
                        end
                    end
                end
                S_SWEEP: begin
                    pot_size         <= pot_size + player_pots[0] + player_pots[1];
                    player_pots[0]   <= '0;
                    player_pots[1]   <= '0;
                    call_size        <= '0;
                    if_BetCheck      <= 1'b1;
                    min_bet_or_raise <= BB_AMT;
                    acted            <= '0;
                    curr_state       <= curr_state + 3'd1;
                    if (curr_state == ST_RIVER) begin
                        state <= S_SHOWDOWN;
                    end else begin
                        deal_req <= 1'b1;
                        state    <= S_DEAL;
                    end
                end
                S_DEAL: begin
                    if (deal_done) begin
                        deal_req       <= 1'b0;
                        current_player <= non_dealer;
                        state          <= skip_bet ? S_SWEEP : S_BET;
                    end
                end
                S_SHOWDOWN: begin
                    if (eval_valid) begin
                        case (eval_result)
                            2'd0: begin winner <= 1'b0; split <= 1'b0; end
                            2'd1: begin winner <= 1'b1; split <= 1'b0; end
                            default: begin winner <= non_dealer; split <= 1'b1; end
                        endcase
                        state <= S_AWARD;
                    end
                end
                S_AWARD: begin
                    player_stacks[0] <= award_stk0;
                    player_stacks[1] <= award_stk1;
                    player_pots[0]   <= '0;
                    player_pots[1]   <= '0;
                    pot_size         <= '0;
                    call_size        <= '0;
                    if_BetCheck      <= 1'b1;
                    hand_done        <= 1'b1;
                    game_over        <= (award_stk0 == '0) || (award_stk1 == '0);
                    state            <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_betting_ctrl.sv
// Self-checking bench for betting_ctrl: directed scenarios plus random hands
// checked against a chip-level model of the betting rules.
module tb_betting_ctrl;

    localparam int unsigned W = 11;
    localparam int START = 1000;
    localparam int SB    = 10;
    localparam int BB    = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_hand, action_valid, deal_done, eval_valid;
    logic [1:0]   action, eval_result;
    logic [W-1:0] raise_amt;
    logic         deal_req, current_player, current_dealer, if_BetCheck;
    logic         winner, hand_done, game_over;
    logic [2:0]   curr_state;
    logic [W-1:0] player_stacks [2];
    logic [W-1:0] player_pots [2];
    logic [W-1:0] pot_size, call_size, min_bet_or_raise;

    always #5 clk = ~clk;

    betting_ctrl #(.STACK_W(W), .START_STACK(START), .SMALL_BLIND(SB), .BIG_BLIND(BB)) dut (
        .clk(clk), .reset(reset), .start_hand(start_hand), .action_valid(action_valid),
        .action(action), .raise_amt(raise_amt), .deal_req(deal_req), .deal_done(deal_done),
        .eval_valid(eval_valid), .eval_result(eval_result), .curr_state(curr_state),
        .current_player(current_player), .current_dealer(current_dealer),
        .player_stacks(player_stacks), .player_pots(player_pots), .pot_size(pot_size),
        .call_size(call_size), .min_bet_or_raise(min_bet_or_raise), .if_BetCheck(if_BetCheck),
        .winner(winner), .hand_done(hand_done), .game_over(game_over)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_deals  = 0;

    // Reference model state
    int m_stk [2];
    int m_pot [2];
    int m_potsize, m_cur, m_dealer, m_minbr, m_street, m_winner;
    bit m_acted [2];
    bit m_skip, m_split, m_gameover;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_stk[0] = START; m_stk[1] = START;
        m_pot[0] = 0;     m_pot[1] = 0;
        m_potsize = 0; m_cur = 0; m_dealer = 1; m_minbr = BB; m_street = 0;
        m_winner = 0; m_skip = 0; m_split = 0; m_gameover = 0;
        m_acted[0] = 0; m_acted[1] = 0;
    endtask

    task automatic check_all(input string tag);
        int owe;
        owe = m_pot[1-m_cur] - m_pot[m_cur];
        check({tag, ".stk0"},   int'(player_stacks[0]), m_stk[0]);
        check({tag, ".stk1"},   int'(player_stacks[1]), m_stk[1]);
        check({tag, ".pot0"},   int'(player_pots[0]), m_pot[0]);
        check({tag, ".pot1"},   int'(player_pots[1]), m_pot[1]);
        check({tag, ".potsz"},  int'(pot_size), m_potsize);
        check({tag, ".cur"},    int'(current_player), m_cur);
        check({tag, ".dealer"}, int'(current_dealer), m_dealer);
        check({tag, ".call"},   int'(call_size), owe);
        check({tag, ".betchk"}, int'(if_BetCheck), (owe == 0) ? 1 : 0);
        check({tag, ".minbr"},  int'(min_bet_or_raise), m_minbr);
        check({tag, ".street"}, int'(curr_state), m_street);
        check({tag, ".gover"},  int'(game_over), m_gameover ? 1 : 0);
        check({tag, ".chips"},  int'(player_stacks[0]) + int'(player_stacks[1]) + int'(player_pots[0])
                                + int'(player_pots[1]) + int'(pot_size), 2 * START);
    endtask

    task automatic start_seq(input string tag);
        int d, bbp, sbp;
        start_hand = 1'b1;
        tick();
        start_hand = 1'b0;
        tick();
        m_dealer = 1 - m_dealer;
        m_street = 0; m_skip = 0; m_minbr = BB;
        m_acted[0] = 0; m_acted[1] = 0;
        d   = m_dealer;
        bbp = (m_stk[1-d] < BB) ? m_stk[1-d] : BB;
        sbp = (m_stk[d] < SB) ? m_stk[d] : SB;
        if (sbp > bbp) sbp = bbp;
        m_stk[d] -= sbp;   m_pot[d] = sbp;
        m_stk[1-d] -= bbp; m_pot[1-d] = bbp;
        m_cur = d;
        check_all(tag);
    endtask

    // One action; model follows the betting rules directly in chip counts
    task automatic act(input int a, input int amt, output bit closed, output bit folded);
        int me, op, owe, put, inc, back;
        closed = 0; folded = 0;
        action_valid = 1'b1; action = 2'(a); raise_amt = W'(amt);
        tick();
        action_valid = 1'b0;
        me = m_cur; op = 1 - me;
        owe = m_pot[op] - m_pot[me];
        if (a == 2) begin
            m_winner = op; m_split = 0; folded = 1;
        end else if (a != 3) begin
            if (a == 1 && m_stk[me] > owe) begin
                inc = (amt > m_minbr) ? amt : m_minbr;
                put = owe + inc;
                if (put > m_stk[me]) put = m_stk[me];
                if (put - owe >= m_minbr) m_minbr = put - owe;
                m_acted[op] = 0;
            end else begin
                put  = (owe < m_stk[me]) ? owe : m_stk[me];
                back = owe - put;
                m_pot[op] -= back; m_stk[op] += back;
            end
            m_stk[me] -= put; m_pot[me] += put;
            m_acted[me] = 1;
            m_cur = op;
            if (m_pot[0] == m_pot[1] &&
                ((m_acted[0] && m_acted[1]) || m_stk[0] == 0 || m_stk[1] == 0)) begin
                closed = 1;
                if (m_stk[0] == 0 || m_stk[1] == 0) m_skip = 1;
            end
        end
        check_all("act");
    endtask

    task automatic award_check(input string tag);
        int total, half;
        tick();
        total = m_potsize + m_pot[0] + m_pot[1];
        if (m_split) begin
            half = total / 2;
            m_stk[m_dealer] += half;
            m_stk[1-m_dealer] += total - half;
        end else begin
            m_stk[m_winner] += total;
        end
        m_pot[0] = 0; m_pot[1] = 0; m_potsize = 0;
        m_gameover = (m_stk[0] == 0 || m_stk[1] == 0);
        check_all(tag);
        check({tag, ".winner"}, int'(winner), m_winner);
        check({tag, ".hdone"}, int'(hand_done), 1);
        tick();
        check({tag, ".hdone_low"}, int'(hand_done), 0);
    endtask

    // Sweep and deal streets until betting resumes or showdown is reached
    task automatic advance();
        int waits;
        do begin
            tick();
            m_potsize += m_pot[0] + m_pot[1];
            m_pot[0] = 0; m_pot[1] = 0;
            m_minbr = BB; m_acted[0] = 0; m_acted[1] = 0;
            m_street++;
            check_all("sweep");
            if (m_street < 4) begin
                check("sweep.dealreq", int'(deal_req), 1);
                waits = $urandom_range(0, 2);
                repeat (waits) begin
                    tick();
                    check("deal.hold", int'(deal_req), 1);
                end
                deal_done = 1'b1;
                tick();
                deal_done = 1'b0;
                n_deals++;
                m_cur = 1 - m_dealer;
                check_all("deal");
                check("deal.dealreq", int'(deal_req), 0);
            end
        end while (m_skip && m_street < 4);
    endtask

    task automatic showdown(input int res);
        check("sd.street", int'(curr_state), 4);
        check("sd.dealreq", int'(deal_req), 0);
        // An action at showdown must be ignored
        action_valid = 1'b1; action = 2'd1; raise_amt = W'(100);
        tick();
        action_valid = 1'b0;
        check_all("sd.ignored");
        eval_valid = 1'b1; eval_result = 2'(res);
        tick();
        eval_valid = 1'b0;
        if (res == 0 || res == 1) begin m_winner = res; m_split = 0; end
        else begin m_winner = 1 - m_dealer; m_split = 1; end
        award_check("award");
    endtask

    task automatic play_random_hand();
        bit closed, folded, done;
        int r, a, amt, guard;
        start_seq("rblinds");
        done = 0; guard = 0;
        while (!done && guard < 200) begin
            guard++;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                deal_done = 1'b1; eval_valid = 1'b1; start_hand = 1'b1;
                tick();
                deal_done = 1'b0; eval_valid = 1'b0; start_hand = 1'b0;
                check_all("bet.ignored");
            end
            a   = (r < 50) ? 0 : (r < 85) ? 1 : (r < 95) ? 2 : 3;
            amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 100);
            act(a, amt, closed, folded);
            if (folded) begin
                award_check("rfold");
                done = 1;
            end else if (closed) begin
                advance();
                if (m_street == 4) begin
                    showdown($urandom_range(0, 3));
                    done = 1;
                end
            end
        end
        if (!done) check("hand_bound", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit closed, folded;
        reset = 1'b1; start_hand = 1'b0; action_valid = 1'b0; action = 2'd0;
        raise_amt = '0; deal_done = 1'b0; eval_valid = 1'b0; eval_result = 2'd0;
        m_reset();
        tick(); tick();
        check_all("reset");
        check("reset.dealreq", int'(deal_req), 0);
        check("reset.hdone", int'(hand_done), 0);
        check("reset.winner", int'(winner), 0);
        reset = 1'b0;
        tick();

        // Hand 1: blinds, limp/check, flop bet/raise/fold
        start_seq("h1.blinds");
        check("h1.dealer", int'(current_dealer), 0);
        check("h1.stk0", int'(player_stacks[0]), 990);
        check("h1.stk1", int'(player_stacks[1]), 980);
        check("h1.call", int'(call_size), 10);
        act(0, 0, closed, folded);
        check("h1.bb_option", int'(closed), 0);
        act(0, 0, closed, folded);
        advance();
        check("h1.potsz", int'(pot_size), 40);
        check("h1.flop_cur", int'(current_player), 1);
        act(1, 5, closed, folded);
        check("h1.minbet", int'(player_pots[1]), 20);
        act(1, 60, closed, folded);
        check("h1.raise", int'(player_pots[0]), 80);
        check("h1.minbr", int'(min_bet_or_raise), 60);
        act(2, 0, closed, folded);
        award_check("h1.fold");
        check("h1.final0", int'(player_stacks[0]), 1040);
        check("h1.final1", int'(player_stacks[1]), 960);

        // Hand 2 from reset: preflop all-in, runout, split
        reset = 1'b1; tick(); reset = 1'b0; m_reset(); tick();
        start_seq("h2.blinds");
        act(1, 2000, closed, folded);
        check("h2.allin_pot", int'(player_pots[0]), 1000);
        check("h2.allin_stk", int'(player_stacks[0]), 0);
        act(0, 0, closed, folded);
        check("h2.closed", int'(closed), 1);
        n_deals = 0;
        advance();
        check("h2.deals", n_deals, 3);
        showdown(2);
        check("h2.split0", int'(player_stacks[0]), 1000);
        check("h2.split1", int'(player_stacks[1]), 1000);

        // Hand 3: dealer P1 shoves, P0 calls, P1 wins everything
        start_seq("h3.blinds");
        act(1, 2000, closed, folded);
        act(0, 0, closed, folded);
        advance();
        showdown(1);
        check("h3.stk1", int'(player_stacks[1]), 2000);
        check("h3.gover", int'(game_over), 1);
        start_hand = 1'b1; tick(); start_hand = 1'b0; tick(); tick();
        check_all("h3.start_ignored");

        // Reset during BET
        reset = 1'b1; tick(); reset = 1'b0; m_reset(); tick();
        start_seq("h4.blinds");
        act(1, 50, closed, folded);
        reset = 1'b1;
        #2;
        m_reset();
        check_all("midreset");
        check("midreset.dealreq", int'(deal_req), 0);
        check("midreset.hdone", int'(hand_done), 0);
        check("midreset.winner", int'(winner), 0);
        tick();
        reset = 1'b0;
        // Events in IDLE are ignored
        action_valid = 1'b1; action = 2'd1; raise_amt = W'(100);
        deal_done = 1'b1; eval_valid = 1'b1;
        tick();
        action_valid = 1'b0; deal_done = 1'b0; eval_valid = 1'b0;
        tick();
        check_all("idle.ignored");

        // Random hands, two sessions
        for (int s = 0; s < 2; s++) begin
            for (int h = 0; h < 40 && !m_gameover; h++) play_random_hand();
            if (m_gameover) begin
                start_hand = 1'b1; tick(); start_hand = 1'b0; tick();
                check_all("rand.gover_ignored");
            end
            reset = 1'b1; tick(); reset = 1'b0; m_reset(); tick();
            check_all("rand.reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
